// File: rtl/dcache_pkg.sv
// Shared definitions for the data cache controller: geometry, timing limits,
// FSM state encoding and the round-robin victim step.
package dcache_pkg;

    localparam int unsigned ADDRBITS  = 32;
    localparam int unsigned DATABITS  = 32;
    localparam int unsigned NUMLINES  = 4;
    localparam int unsigned BURSTLEN  = 32;
    localparam int unsigned LKTIMEOUT = 16;

    localparam int unsigned VICTBITS  = $clog2(NUMLINES);
    localparam int unsigned TMOBITS   = $clog2(LKTIMEOUT);
    localparam int unsigned BEATBITS  = 6;

    typedef enum logic [1:0] {
        StIdle,
        StLookup,
        StFill,
        StReplay
    } state_e;

    function automatic logic [VICTBITS-1:0] next_victim(input logic [VICTBITS-1:0] v);
        return (v == VICTBITS'(NUMLINES - 1)) ? '0 : v + 1'b1;
    endfunction

endpackage

// File: rtl/dcache_memarb.sv
// External memory arbiter: hands the external port to the victim line during a
// fill and counts returned read beats until the burst is complete.
module dcache_memarb
    import dcache_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         fill_active,
    input  logic [VICTBITS-1:0]          victim,
    input  logic [DATABITS*NUMLINES-1:0] line_out,
    input  logic [ADDRBITS*NUMLINES-1:0] line_mem_addr,
    input  logic [NUMLINES-1:0]          line_mem_rdreq,
    input  logic [NUMLINES-1:0]          line_mem_wrreq,
    input  logic [DATABITS-1:0]          ext_rddata,
    input  logic                         ext_rdvalid,
    output logic [ADDRBITS-1:0]          ext_addr,
    output logic                         ext_rdreq,
    output logic                         ext_wrreq,
    output logic [DATABITS-1:0]          ext_wrdata,
    output logic [DATABITS-1:0]          line_mem_out,
    output logic [NUMLINES-1:0]          line_mem_valid,
    output logic                         fill_done
);

    logic [BEATBITS-1:0] beat_q;

    always_comb begin
        ext_addr       = line_mem_addr[victim*ADDRBITS +: ADDRBITS];
        ext_wrdata     = line_out[victim*DATABITS +: DATABITS];
        ext_rdreq      = fill_active & line_mem_rdreq[victim];
        ext_wrreq      = fill_active & line_mem_wrreq[victim];
        line_mem_out   = ext_rddata;
        line_mem_valid = '0;
        if (fill_active) begin
            line_mem_valid[victim] = ext_rdvalid;
        end
        fill_done = fill_active && ext_rdvalid && (beat_q == BEATBITS'(BURSTLEN - 1));
    end

    // Only read beats advance the count; write-back traffic shares the port uncounted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_q <= '0;
        end else if (!fill_active) begin
            beat_q <= '0;
        end else if (ext_rdvalid) begin
            beat_q <= beat_q + 1'b1;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Data cache controller: broadcasts CPU requests to the lines, resolves hit/miss,
// runs a round-robin fill on a full miss and replays the request once.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [ADDRBITS-1:0]          cpu_addr,
    input  logic [DATABITS-1:0]          cpu_datain,
    input  logic                         cpu_rdreq,
    input  logic                         cpu_wrreq,
    output logic [DATABITS-1:0]          cpu_dataout,
    output logic                         cpu_valid,
    output logic                         cpu_error,
    output logic                         cpu_busy,
    output logic [ADDRBITS-1:0]          line_addr,
    output logic [DATABITS-1:0]          line_datain,
    output logic                         line_rdreq,
    output logic                         line_wrreq,
    output logic [NUMLINES-1:0]          line_fill,
    input  logic [DATABITS*NUMLINES-1:0] line_out,
    input  logic [NUMLINES-1:0]          line_valid,
    input  logic [NUMLINES-1:0]          line_miss,
    input  logic [ADDRBITS*NUMLINES-1:0] line_mem_addr,
    input  logic [NUMLINES-1:0]          line_mem_rdreq,
    input  logic [NUMLINES-1:0]          line_mem_wrreq,
    output logic [DATABITS-1:0]          line_mem_out,
    output logic [NUMLINES-1:0]          line_mem_valid,
    output logic [15:0]                  line_mem_burstlen,
    output logic [ADDRBITS-1:0]          ext_addr,
    output logic                         ext_rdreq,
    output logic                         ext_wrreq,
    output logic [DATABITS-1:0]          ext_wrdata,
    output logic [15:0]                  ext_burstlen,
    input  logic [DATABITS-1:0]          ext_rddata,
    input  logic                         ext_rdvalid
);

    state_e              state_q;
    logic [ADDRBITS-1:0] req_addr_q;
    logic [DATABITS-1:0] req_data_q;
    logic                req_wr_q;
    logic [VICTBITS-1:0] victim_q;
    logic [TMOBITS-1:0]  tmo_q;
    logic                replay_q;
    logic [DATABITS-1:0] hit_data;
    logic                fill_done;

    assign line_addr         = req_addr_q;
    assign line_datain       = req_data_q;
    assign line_mem_burstlen = 16'(BURSTLEN);
    assign ext_burstlen      = 16'(BURSTLEN);

    // Lowest-indexed hitting line wins when several report a hit.
    always_comb begin
        hit_data = '0;
        for (int i = NUMLINES - 1; i >= 0; i--) begin
            if (line_valid[i]) begin
                hit_data = line_out[i*DATABITS +: DATABITS];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_wr_q    <= 1'b0;
            cpu_dataout <= '0;
            cpu_valid   <= 1'b0;
            cpu_error   <= 1'b0;
            cpu_busy    <= 1'b0;
            line_rdreq  <= 1'b0;
            line_wrreq  <= 1'b0;
            line_fill   <= '0;
            victim_q    <= '0;
            tmo_q       <= '0;
            replay_q    <= 1'b0;
        end else begin
            cpu_valid  <= 1'b0;
            cpu_error  <= 1'b0;
            line_rdreq <= 1'b0;
            line_wrreq <= 1'b0;
            line_fill  <= '0;
            unique case (state_q)
                StIdle: begin
                    if (cpu_rdreq || cpu_wrreq) begin
                        req_addr_q <= cpu_addr;
                        req_data_q <= cpu_datain;
                        req_wr_q   <= !cpu_rdreq;
                        line_rdreq <= cpu_rdreq;
                        line_wrreq <= !cpu_rdreq;
                        cpu_busy   <= 1'b1;
                        replay_q   <= 1'b0;
                        tmo_q      <= '0;
                        state_q    <= StLookup;
                    end
                end
                StLookup: begin
                    if (|line_valid) begin
                        cpu_dataout <= hit_data;
                        cpu_valid   <= 1'b1;
                        cpu_busy    <= 1'b0;
                        state_q     <= StIdle;
                    end else if (&line_miss && !replay_q) begin
                        line_fill <= NUMLINES'(1) << victim_q;
                        state_q   <= StFill;
                    end else if (&line_miss || tmo_q == TMOBITS'(LKTIMEOUT - 1)) begin
                        // A miss after the replay is final; no second fill is attempted.
                        cpu_valid <= 1'b1;
                        cpu_error <= 1'b1;
                        cpu_busy  <= 1'b0;
                        state_q   <= StIdle;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StFill: begin
                    if (fill_done) begin
                        victim_q <= next_victim(victim_q);
                        state_q  <= StReplay;
                    end
                end
                StReplay: begin
                    line_rdreq <= !req_wr_q;
                    line_wrreq <= req_wr_q;
                    replay_q   <= 1'b1;
                    tmo_q      <= '0;
                    state_q    <= StLookup;
                end
            endcase
        end
    end

    dcache_memarb u_memarb (
        .clk            (clk),
        .reset_n        (reset_n),
        .fill_active    (state_q == StFill),
        .victim         (victim_q),
        .line_out       (line_out),
        .line_mem_addr  (line_mem_addr),
        .line_mem_rdreq (line_mem_rdreq),
        .line_mem_wrreq (line_mem_wrreq),
        .ext_rddata     (ext_rddata),
        .ext_rdvalid    (ext_rdvalid),
        .ext_addr       (ext_addr),
        .ext_rdreq      (ext_rdreq),
        .ext_wrreq      (ext_wrreq),
        .ext_wrdata     (ext_wrdata),
        .line_mem_out   (line_mem_out),
        .line_mem_valid (line_mem_valid),
        .fill_done      (fill_done)
    );

endmodule
